// File: rtl/detect_sequence_pkg.sv
// Shared types and helpers for the multi-pattern serial sequence detector.
// Pattern-side types are sized by PAT_W; the top-level W must match it.
// Counter width is a per-instance parameter, so cnt_t is only the default width.
package detect_sequence_pkg;

    localparam int unsigned PAT_W     = 8;
    localparam int unsigned LANES     = 4;
    localparam int unsigned DEF_CNT_W = 16;
    localparam int unsigned LEN_W     = $clog2(PAT_W + 1);

    typedef logic [LEN_W-1:0]     len_t;
    typedef logic [LEN_W-1:0]     fill_t;
    typedef logic [PAT_W-1:0]     pat_t;
    typedef logic [DEF_CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic en;
        logic ovl;
        len_t len;
        pat_t pat;
    } lane_cfg_t;

    // A pattern must be at least two bits and no longer than the history window.
    function automatic logic len_legal(input len_t len);
        return (len >= LEN_W'(2)) && (len <= LEN_W'(PAT_W));
    endfunction

endpackage

// File: rtl/detect_sequence_multi_if.sv
// Stream, configuration and result signals of detect_sequence_multi.
// master: drives in_vld/in, cfg_*, cnt_clr; observes match_r, cnt_r, cfg_err_r.
// slave : the detector side of the same signals.
interface detect_sequence_multi_if #(
    parameter int unsigned W     = detect_sequence_pkg::PAT_W,
    parameter int unsigned N     = detect_sequence_pkg::LANES,
    parameter int unsigned CNT_W = detect_sequence_pkg::DEF_CNT_W
);
    logic                     in_vld;
    logic                     in;
    logic                     cfg_vld;
    logic [$clog2(N)-1:0]     cfg_id;
    logic                     cfg_en;
    logic                     cfg_ovl;
    logic [$clog2(W+1)-1:0]   cfg_len;
    logic [W-1:0]             cfg_pat;
    logic                     cnt_clr;
    logic [N-1:0]             match_r;
    logic [N*CNT_W-1:0]       cnt_r;
    logic                     cfg_err_r;

    modport master (
        output in_vld, in, cfg_vld, cfg_id, cfg_en, cfg_ovl, cfg_len, cfg_pat, cnt_clr,
        input  match_r, cnt_r, cfg_err_r
    );

    modport slave (
        input  in_vld, in, cfg_vld, cfg_id, cfg_en, cfg_ovl, cfg_len, cfg_pat, cnt_clr,
        output match_r, cnt_r, cfg_err_r
    );
endinterface

// File: rtl/detect_sequence_lane.sv
// One pattern lane: holds its configuration, beat fill counter, hit compare,
// registered match pulse and saturating match counter.
// Ports: clk, rst_n; window (history + current bit, newest at bit 0), in_vld,
// cfg_wr/cfg_new (legal config write for this lane), cnt_clr;
// match_r (one-cycle pulse per hit), cnt_r (saturating hit count).
module detect_sequence_lane
    import detect_sequence_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  pat_t             window,
    input  logic             in_vld,
    input  logic             cfg_wr,
    input  lane_cfg_t        cfg_new,
    input  logic             cnt_clr,
    output logic             match_r,
    output logic [CNT_W-1:0] cnt_r
);

    lane_cfg_t cfg_r;
    fill_t     fill_r;

    pat_t mask_c;
    len_t len_m1_c;
    logic hit_c;

    // Compare only the low len bits; fill guarantees the window holds len real beats.
    always_comb begin
        mask_c   = pat_t'((32'd1 << cfg_r.len) - 32'd1);
        len_m1_c = cfg_r.len - LEN_W'(1);
        hit_c    = in_vld && cfg_r.en && (fill_r >= len_m1_c)
                   && ((window & mask_c) == (cfg_r.pat & mask_c));
    end

    // Configuration; a write always restarts the fill count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_r  <= '0;
            fill_r <= '0;
        end else begin
            if (cfg_wr) begin
                cfg_r <= cfg_new;
            end
            if (cfg_wr) begin
                fill_r <= '0;
            end else if (hit_c && !cfg_r.ovl) begin
                fill_r <= '0;
            end else if (in_vld && (fill_r != LEN_W'(PAT_W))) begin
                fill_r <= fill_r + LEN_W'(1);
            end
        end
    end

    // Match pulse and saturating counter; clear beats a coincident hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            match_r <= hit_c;
            if (cnt_clr) begin
                cnt_r <= '0;
            end else if (hit_c && (cnt_r != '1)) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/detect_sequence_multi.sv
// Runtime-programmable multi-pattern serial sequence detector.
// Ports: clk, rst_n (async active-low); bus (slave modport) carrying the
// qualified bit stream, lane configuration writes, counter clear, per-lane
// match pulses, per-lane match counters and the illegal-config pulse.
// W must equal detect_sequence_pkg::PAT_W; N and CNT_W are free.
module detect_sequence_multi
    import detect_sequence_pkg::*;
#(
    parameter int unsigned W     = PAT_W,
    parameter int unsigned N     = LANES,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    detect_sequence_multi_if.slave  bus
);

    localparam int unsigned ID_W = $clog2(N);

    logic [PAT_W-2:0]   hist_r;
    logic               cfg_err_r;
    pat_t               window_c;
    lane_cfg_t          cfg_new_c;
    logic               cfg_ok_c;
    logic [N-1:0]       match_v;
    logic [N*CNT_W-1:0] cnt_v;

    // Current bit is the newest element of every lane's window.
    always_comb begin
        window_c  = {hist_r, bus.in};
        cfg_ok_c  = len_legal(bus.cfg_len);
        cfg_new_c = '{en: bus.cfg_en, ovl: bus.cfg_ovl, len: bus.cfg_len, pat: bus.cfg_pat};
    end

    // Bit history, advancing only on qualified beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_r <= '0;
        end else if (bus.in_vld) begin
            hist_r <= {hist_r[PAT_W-3:0], bus.in};
        end
    end

    // Illegal-length writes are dropped and flagged for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= bus.cfg_vld && !cfg_ok_c;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic wr_c;
        assign wr_c = bus.cfg_vld && cfg_ok_c && (bus.cfg_id == ID_W'(i));

        detect_sequence_lane #(
            .CNT_W (CNT_W)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .window  (window_c),
            .in_vld  (bus.in_vld),
            .cfg_wr  (wr_c),
            .cfg_new (cfg_new_c),
            .cnt_clr (bus.cnt_clr),
            .match_r (match_v[i]),
            .cnt_r   (cnt_v[i*CNT_W +: CNT_W])
        );
    end

    assign bus.match_r   = match_v;
    assign bus.cnt_r     = cnt_v;
    assign bus.cfg_err_r = cfg_err_r;

endmodule
